// File: rtl/taxi_pkg.sv
// Shared fare-meter definitions: FSM state encoding, default tariff constants
// and the saturating fare accumulator used by the top level.
package taxi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } fare_state_e;

  localparam int unsigned DEF_BASE_FARE = 1300;
  localparam int unsigned DEF_BASE_DIST = 3000;
  localparam int unsigned DEF_STEP_DIST = 500;
  localparam int unsigned DEF_STEP_LOW  = 100;
  localparam int unsigned DEF_STEP_HIGH = 150;
  localparam int unsigned DEF_FAR_DIST  = 10000;
  localparam int unsigned DEF_WAIT_STEP = 6000;
  localparam int unsigned DEF_WAIT_FEE  = 50;
  localparam int unsigned DEF_FARE_MAX  = 999999;

  // Two extra headroom bits so the sum can never wrap before it is clamped.
  function automatic logic [31:0] sat_add(input logic [31:0] fare,
                                          input logic [31:0] inc_a,
                                          input logic [31:0] inc_b,
                                          input logic [31:0] ceiling);
    logic [33:0] sum;
    sum = {2'b00, fare} + {2'b00, inc_a} + {2'b00, inc_b};
    return (sum > {2'b00, ceiling}) ? ceiling : sum[31:0];
  endfunction

endpackage

// File: rtl/taxi_mark_counter.sv
// Tracks the next billing threshold for one cumulative input (distance or wait):
// compares, advances one step per billed crossing, and slides past paused spans.
module taxi_mark_counter
  import taxi_pkg::*;
#(
  parameter int unsigned MARK_OFFSET  = DEF_BASE_DIST + DEF_STEP_DIST,
  parameter int unsigned LIMIT_OFFSET = DEF_FAR_DIST,
  parameter int unsigned STEP         = DEF_STEP_DIST,
  parameter int unsigned FEE_NEAR     = DEF_STEP_LOW,
  parameter int unsigned FEE_FAR      = DEF_STEP_HIGH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value_i,
  input  logic        load_i,
  input  logic        bill_i,
  input  logic        capture_i,
  input  logic        resume_i,
  output logic [31:0] fee_o
);

  localparam logic [31:0] MARK_W  = 32'(MARK_OFFSET);
  localparam logic [31:0] LIMIT_W = 32'(LIMIT_OFFSET);
  localparam logic [31:0] STEP_W  = 32'(STEP);
  localparam logic [31:0] NEAR_W  = 32'(FEE_NEAR);
  localparam logic [31:0] FAR_W   = 32'(FEE_FAR);

  logic [31:0] mark_q, mark_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] cap_q, cap_d;
  logic [31:0] shift;
  logic        hit;
  logic        advance;

  assign hit     = value_i >= mark_q;
  assign advance = bill_i && hit;
  assign shift   = value_i - cap_q;

  // The limit moves with the mark, so the near/far decision stays relative to trip start.
  assign fee_o = advance ? ((mark_q <= limit_q) ? NEAR_W : FAR_W) : '0;

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
    mark_d  = mark_q;
    limit_d = limit_q;
    cap_d   = cap_q;
    if (load_i) begin
      mark_d  = value_i + MARK_W;
      limit_d = value_i + LIMIT_W;
    end else if (resume_i) begin
      mark_d  = mark_q + shift;
      limit_d = limit_q + shift;
    end else if (advance) begin
      mark_d  = mark_q + STEP_W;
    end
    if (capture_i) cap_d = value_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mark_q  <= '0;
      limit_q <= '0;
      cap_q   <= '0;
    end else begin
      mark_q  <= mark_d;
      limit_q <= limit_d;
      cap_q   <= cap_d;
    end
  end

endmodule

// File: rtl/taxi_fare.sv
// Taxi meter: trip FSM driven by the start button edge and pause level,
// accumulating distance and waiting charges into a saturating fare register.
module taxi_fare
  import taxi_pkg::*;
#(
  parameter int unsigned BASE_FARE = DEF_BASE_FARE,
  parameter int unsigned BASE_DIST = DEF_BASE_DIST,
  parameter int unsigned STEP_DIST = DEF_STEP_DIST,
  parameter int unsigned STEP_LOW  = DEF_STEP_LOW,
  parameter int unsigned STEP_HIGH = DEF_STEP_HIGH,
  parameter int unsigned FAR_DIST  = DEF_FAR_DIST,
  parameter int unsigned WAIT_STEP = DEF_WAIT_STEP,
  parameter int unsigned WAIT_FEE  = DEF_WAIT_FEE,
  parameter int unsigned FARE_MAX  = DEF_FARE_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pause,
  input  logic [31:0] distance,
  input  logic [31:0] wait_time,
  output logic [31:0] money,
  output logic [1:0]  fare_state
);

  localparam logic [31:0] FARE_MAX_W = 32'(FARE_MAX);
  localparam logic [31:0] BASE_W     = (BASE_FARE > FARE_MAX) ? FARE_MAX_W : 32'(BASE_FARE);

  fare_state_e state_q, state_d;
  logic        start_q;
  logic        start_edge;
  logic        enter_run, capture, resume, bill;
  logic [31:0] money_q, money_d;
  logic [31:0] dist_fee, wait_fee;

  assign start_edge = start && !start_q;

  taxi_mark_counter #(
    .MARK_OFFSET (BASE_DIST + STEP_DIST),
    .LIMIT_OFFSET(FAR_DIST),
    .STEP        (STEP_DIST),
    .FEE_NEAR    (STEP_LOW),
    .FEE_FAR     (STEP_HIGH)
  ) u_dist (
    .clk      (clk),
    .rst      (rst),
    .value_i  (distance),
    .load_i   (enter_run),
    .bill_i   (bill),
    .capture_i(capture),
    .resume_i (resume),
    .fee_o    (dist_fee)
  );

  // Waiting is billed at a flat rate, so both fee slots carry the same value.
  taxi_mark_counter #(
    .MARK_OFFSET (WAIT_STEP),
    .LIMIT_OFFSET(0),
    .STEP        (WAIT_STEP),
    .FEE_NEAR    (WAIT_FEE),
    .FEE_FAR     (WAIT_FEE)
  ) u_wait (
    .clk      (clk),
    .rst      (rst),
    .value_i  (wait_time),
    .load_i   (enter_run),
    .bill_i   (bill),
    .capture_i(capture),
    .resume_i (resume),
    .fee_o    (wait_fee)
  );

  always_comb begin
    state_d   = state_q;
    enter_run = 1'b0;
    capture   = 1'b0;
    resume    = 1'b0;
    bill      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_d   = ST_RUN;
          enter_run = 1'b1;
        end
      end
      ST_RUN: begin
        if (start_edge) begin
          state_d = ST_DONE;
        end else if (pause) begin
          state_d = ST_HOLD;
          capture = 1'b1;
        end else begin
          bill = 1'b1;
        end
      end
      ST_HOLD: begin
        if (start_edge) begin
          state_d = ST_DONE;
        end else if (!pause) begin
          state_d = ST_RUN;
          resume  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    money_d = money_q;
    if (enter_run)  money_d = BASE_W;
    else if (bill)  money_d = sat_add(money_q, dist_fee, wait_fee, FARE_MAX_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      money_q <= '0;
    end else begin
      // NOTE: non-blocking updates let every register see the pre-edge values of the others.
      state_q <= state_d;
      start_q <= start;
      money_q <= money_d;
    end
  end

  assign money      = money_q;
  assign fare_state = state_q;

endmodule

// File: doc/taxi_fare.md
TAXI_FARE -- requirements
Module: taxi_fare

Interface
REQ-001 SHALL have parameter BASE_FARE, 1300, fare in fen charged at trip start (covers first BASE_DIST).
REQ-002 SHALL have parameter BASE_DIST, 3000, metres included in base fare.
REQ-003 SHALL have parameter STEP_DIST, 500, metres per distance increment.
REQ-004 SHALL have parameters STEP_LOW, 100 and STEP_HIGH, 150, fen per step ending at or below / above FAR_DIST.
REQ-005 SHALL have parameter FAR_DIST, 10000, trip metres where the high rate begins.
REQ-006 SHALL have parameters WAIT_STEP, 6000 and WAIT_FEE, 50, wait ticks (0.01 s) per wait increment / fen per increment.
REQ-007 SHALL have parameter FARE_MAX, 999999, saturation ceiling in fen.
REQ-008 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-009 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-010 SHALL have port start, input, 1, trip start/stop button (level; rising edge acts).
REQ-011 SHALL have port pause, input, 1, level; high suspends billing.
REQ-012 SHALL have port distance, input, 32, cumulative metres from taxi_distance, monotonic non-decreasing.
REQ-013 SHALL have port wait_time, input, 32, cumulative wait ticks (0.01 s) from taxi_distance, monotonic non-decreasing.
REQ-014 SHALL have port money, output, 32, current fare in fen, registered.
REQ-015 SHALL have port fare_state, output, 2, IDLE=0, RUN=1, HOLD=2, DONE=3.

Function
REQ-016 SHALL detect start rising edge with a registered previous value; holding start high SHALL act once.
REQ-017 SHALL FSM: IDLE --edge--> RUN; RUN --pause--> HOLD; HOLD --!pause--> RUN; RUN/HOLD --edge--> DONE; DONE --edge--> RUN.
REQ-018 SHALL on entering RUN from IDLE/DONE: money<=BASE_FARE; dist_mark<=distance+BASE_DIST+STEP_DIST; far_mark<=distance+FAR_DIST; wait_mark<=wait_time+WAIT_STEP.
REQ-019 SHALL in RUN, each cycle distance>=dist_mark: add STEP_LOW if dist_mark<=far_mark else STEP_HIGH; dist_mark+=STEP_DIST; at most one distance step per cycle (catch-up over successive cycles).
REQ-020 SHALL in RUN, each cycle wait_time>=wait_mark: add WAIT_FEE; wait_mark+=WAIT_STEP; at most one wait step per cycle.
REQ-021 SHALL add both increments in the same cycle when both crossings coincide.
REQ-022 SHALL update money one cycle after the sampled crossing (latency 1).
REQ-023 SHALL saturate money at FARE_MAX; never wrap.
REQ-024 SHALL on RUN->HOLD capture distance and wait_time; on HOLD->RUN add (current-captured) to dist_mark, far_mark, wait_mark so paused travel/wait is never billed.
REQ-025 SHALL freeze money in HOLD and DONE; money=0 only in IDLE.
REQ-026 SHALL give start edge priority over pause in same cycle (RUN/HOLD -> DONE).
REQ-027 SHALL use 32-bit unsigned compares; trip distances >= 2^31 unsupported.

Reset
REQ-028 SHALL on rst asynchronously force state IDLE, money 0, fare_state 0, all marks/captures 0, start-edge register 0.
REQ-029 SHALL treat reset mid-trip as trip abandoned; next start edge begins fresh trip.

Structure
REQ-030 SHALL place fare state encoding and default fare constants in shared package taxi_pkg.
REQ-031 SHALL implement mark tracking (compare, advance, pause-shift) as sub-module taxi_mark_counter, instantiated twice (distance, wait).

Verification
REQ-032 SHALL: start edge with distance=0, ramp to 3499 -> money 1300; at 3500 -> 1400 next cycle.
REQ-033 SHALL: distance jumps 0->11000 in one cycle -> money climbs one step/cycle to 1300+14*100+2*150=3000 after 16 cycles.
REQ-034 SHALL: wait_time 0->6000 and distance crossing 3500 same cycle -> money 1300->1450 in one cycle.
REQ-035 SHALL: pause high, distance +2000, pause low, distance +500 past 3000 -> exactly one step billed (1400).
REQ-036 SHALL: start held high 10 cycles -> single IDLE->RUN; second edge -> DONE, money frozen; third edge -> RUN, money 1300.
REQ-037 SHALL: rst asserted mid-RUN between clock edges -> money 0, fare_state 0 immediately; FARE_MAX=1500 case saturates at 1500.
